// File: rtl/survivor_ram_pkg.sv
// Shared widths/defaults for the survivor-path memory and its read-control word.
// The macros give the codebase-wide defaults picked up by the top's parameters.
`ifndef WD_RAM_ADDRESS
`define WD_RAM_ADDRESS 2
`endif
`ifndef WD_SURV_DATA
`define WD_SURV_DATA 8
`endif
`ifndef SURV_READ_FIRST
`define SURV_READ_FIRST 1
`endif

package survivor_ram_pkg;

  // Per-read control captured alongside the array read.
  typedef struct packed {
    logic err;   // offset beyond stored history
    logic zero;  // force data to 0 (miss or post-reset)
    logic byp;   // return captured write data instead of array data
  } rd_ctl_t;

  localparam rd_ctl_t RD_CTL_RESET = '{err: 1'b0, zero: 1'b1, byp: 1'b0};

endpackage

// File: rtl/ram_sdp_core.sv
// Simple dual-port array: one synchronous write port, one registered read port.
// Latency: read data 1 cycle after rd_en; output holds while rd_en is low.
// Backpressure: none; no reset so the array maps onto block RAM.
module ram_sdp_core #(
  parameter int WD_DATA = 8,
  parameter int WD_ADDR = 2
) (
  input  logic               WCLK,
  input  logic               wr_en,
  input  logic [WD_ADDR-1:0] wr_addr,
  input  logic [WD_DATA-1:0] wr_dat,
  input  logic               rd_en,
  input  logic [WD_ADDR-1:0] rd_addr,
  output logic [WD_DATA-1:0] rd_dat
);

  logic [WD_DATA-1:0] mem [2**WD_ADDR];

  // Same-address read and write return the old contents.
  always_ff @(posedge WCLK) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/survivor_ram.sv
// Circular survivor-path buffer: one decision vector written per cycle, read back by age.
// Latency: write visible next cycle; read result exactly 1 cycle after rd_req.
// Backpressure: none; writes always accepted, oldest word overwritten once full.
module survivor_ram
  import survivor_ram_pkg::*;
#(
  parameter int WD_DATA    = `WD_SURV_DATA,
  parameter int WD_ADDR    = `WD_RAM_ADDRESS,
  parameter bit READ_FIRST = `SURV_READ_FIRST
) (
  input  logic               WCLK,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr_vld,
  input  logic [WD_DATA-1:0] wr_dat,
  input  logic               rd_req,
  input  logic [WD_ADDR-1:0] rd_offset,
  output logic               rd_vld,
  output logic [WD_DATA-1:0] rd_dat,
  output logic               rd_err,
  output logic [WD_ADDR:0]   count,
  output logic               full
);

  localparam logic [WD_ADDR:0] CNT_MAX = (WD_ADDR+1)'(2**WD_ADDR);

  logic [WD_ADDR-1:0] wr_ptr;
  logic [WD_ADDR-1:0] rd_addr;
  logic [WD_ADDR-1:0] wr_addr;
  logic [WD_ADDR:0]   count_inc;
  logic               hit;
  logic               coll;
  logic               mem_we;
  logic [WD_DATA-1:0] core_q;
  logic [WD_DATA-1:0] byp_dat_q;
  rd_ctl_t            ctl_q;

  // All read decisions use the pre-edge pointer and occupancy.
  assign rd_addr   = wr_ptr - WD_ADDR'(1) - rd_offset;
  assign hit       = {1'b0, rd_offset} < count;
  assign coll      = full & wr_vld & (rd_addr == wr_ptr);
  assign mem_we    = wr_vld & ~reset;
  assign wr_addr   = flush ? '0 : wr_ptr;
  assign count_inc = count + 1'b1;

  ram_sdp_core #(
    .WD_DATA (WD_DATA),
    .WD_ADDR (WD_ADDR)
  ) u_core (
    .WCLK    (WCLK),
    .wr_en   (mem_we),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat),
    .rd_en   (rd_req),
    .rd_addr (rd_addr),
    .rd_dat  (core_q)
  );

  always_ff @(posedge WCLK) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= WD_ADDR'(wr_vld);
      count  <= (WD_ADDR+1)'(wr_vld);
      full   <= 1'b0;
    end else if (wr_vld) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) begin
        count <= count_inc;
        full  <= (count_inc == CNT_MAX);
      end
    end
  end

  // Flags and bypass data only move on a request, so outputs hold while idle.
  always_ff @(posedge WCLK) begin
    if (reset) begin
      rd_vld <= 1'b0;
      ctl_q  <= RD_CTL_RESET;
    end else begin
      rd_vld <= rd_req;
      if (rd_req) begin
        ctl_q.err  <= ~hit;
        ctl_q.zero <= ~hit;
        ctl_q.byp  <= hit & coll & ~READ_FIRST;
        byp_dat_q  <= wr_dat;
      end
    end
  end

  assign rd_err = ctl_q.err;
  assign rd_dat = ctl_q.zero ? '0 : (ctl_q.byp ? byp_dat_q : core_q);

endmodule

// File: tb/tb_survivor_ram.sv
// Bench for survivor_ram: both collision modes side by side against a queue-based history model.
module tb_survivor_ram;

  localparam int WD_DATA = 8;
  localparam int WD_ADDR = 2;
  localparam int DEPTH   = 4;

  logic               WCLK = 1'b0;
  logic               reset = 1'b0;
  logic               flush = 1'b0;
  logic               wr_vld = 1'b0;
  logic [WD_DATA-1:0] wr_dat = '0;
  logic               rd_req = 1'b0;
  logic [WD_ADDR-1:0] rd_offset = '0;

  logic               rf_vld, wf_vld, rf_err, wf_err, rf_full, wf_full;
  logic [WD_DATA-1:0] rf_dat, wf_dat;
  logic [WD_ADDR:0]   rf_count, wf_count;

  always #5 WCLK = ~WCLK;

  survivor_ram #(.WD_DATA(WD_DATA), .WD_ADDR(WD_ADDR), .READ_FIRST(1'b1)) u_dut_rf (
    .WCLK(WCLK), .reset(reset), .flush(flush), .wr_vld(wr_vld), .wr_dat(wr_dat),
    .rd_req(rd_req), .rd_offset(rd_offset), .rd_vld(rf_vld), .rd_dat(rf_dat),
    .rd_err(rf_err), .count(rf_count), .full(rf_full)
  );

  survivor_ram #(.WD_DATA(WD_DATA), .WD_ADDR(WD_ADDR), .READ_FIRST(1'b0)) u_dut_wf (
    .WCLK(WCLK), .reset(reset), .flush(flush), .wr_vld(wr_vld), .wr_dat(wr_dat),
    .rd_req(rd_req), .rd_offset(rd_offset), .rd_vld(wf_vld), .rd_dat(wf_dat),
    .rd_err(wf_err), .count(wf_count), .full(wf_full)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: stored history, newest word at index 0.
  logic [WD_DATA-1:0] hist[$];
  logic [WD_DATA-1:0] exp_dat_rf = '0;
  logic [WD_DATA-1:0] exp_dat_wf = '0;
  logic               exp_err    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic wv,
                       input logic [WD_DATA-1:0] wd, input logic rq,
                       input logic [WD_ADDR-1:0] off);
    logic exp_vld;
    reset = rst; flush = fl; wr_vld = wv; wr_dat = wd; rd_req = rq; rd_offset = off;
    @(posedge WCLK);
    #1;
    exp_vld = rq && !rst;
    if (rst) begin
      hist.delete();
      exp_dat_rf = '0;
      exp_dat_wf = '0;
      exp_err    = 1'b0;
    end else begin
      if (rq) begin
        if (int'(off) < hist.size()) begin
          exp_dat_rf = hist[off];
          exp_dat_wf = (hist.size() == DEPTH && wv && int'(off) == DEPTH-1) ? wd : hist[off];
          exp_err    = 1'b0;
        end else begin
          exp_dat_rf = '0;
          exp_dat_wf = '0;
          exp_err    = 1'b1;
        end
      end
      if (fl) hist.delete();
      if (wv) begin
        hist.push_front(wd);
        if (hist.size() > DEPTH) void'(hist.pop_back());
      end
    end
    chk("rf_vld",   32'(rf_vld),   32'(exp_vld));
    chk("wf_vld",   32'(wf_vld),   32'(exp_vld));
    chk("rf_dat",   32'(rf_dat),   32'(exp_dat_rf));
    chk("wf_dat",   32'(wf_dat),   32'(exp_dat_wf));
    chk("rf_err",   32'(rf_err),   32'(exp_err));
    chk("wf_err",   32'(wf_err),   32'(exp_err));
    chk("rf_count", 32'(rf_count), 32'(hist.size()));
    chk("wf_count", 32'(wf_count), 32'(hist.size()));
    chk("rf_full",  32'(rf_full),  32'(hist.size() == DEPTH));
    chk("wf_full",  32'(wf_full),  32'(hist.size() == DEPTH));
    reset = 1'b0; flush = 1'b0; wr_vld = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    cycle(1, 0, 0, 8'h00, 0, 0);
    cycle(1, 0, 0, 8'h00, 0, 0);

    // Two words, read back newest first, then one past the history.
    cycle(0, 0, 1, 8'hA5, 0, 0);
    cycle(0, 0, 1, 8'h3C, 0, 0);
    cycle(0, 0, 0, 8'h00, 1, 0);
    cycle(0, 0, 0, 8'h00, 1, 1);
    cycle(0, 0, 0, 8'h00, 1, 2);
    cycle(0, 0, 0, 8'h00, 0, 0);

    // Wrap past full, then read the whole window.
    for (int i = 1; i <= 6; i++) cycle(0, 0, 1, 8'(i), 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 8'h00, 1, 2'(i));

    // Oldest-word read colliding with a write, then the new word at offset 0.
    cycle(0, 0, 1, 8'h77, 1, 3);
    cycle(0, 0, 0, 8'h00, 1, 0);

    // Flush with a write lands at address 0 as the only valid word.
    cycle(0, 1, 1, 8'h9E, 0, 0);
    cycle(0, 0, 0, 8'h00, 1, 0);
    cycle(0, 0, 0, 8'h00, 1, 1);

    // Reset alongside a read with three words stored.
    cycle(0, 0, 1, 8'h11, 0, 0);
    cycle(0, 0, 1, 8'h22, 1, 0);
    cycle(1, 0, 0, 8'h00, 1, 1);
    cycle(0, 0, 0, 8'h00, 1, 0);

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 49) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1,
            8'($urandom),
            $urandom_range(0, 9) < 6,
            2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/survivor_ram.md
# survivor_ram

Single-clock, parametrised survivor-path memory for the Viterbi decoder, replacing the split-clock, shared-bus RAM in the traceback path. The add-compare-select stage writes one decision vector per cycle into a circular buffer. The traceback unit reads any of the last DEPTH vectors by age offset and gets registered data one cycle later. Adds occupancy tracking, an out-of-range flag, flush, and a defined read/write collision rule.

## Interface
Parameters:
- WD_DATA, default 8: decision-vector width in bits.
- WD_ADDR, default `WD_RAM_ADDRESS: address width. DEPTH = 2**WD_ADDR.
- READ_FIRST, default 1: on a collision, 1 returns the old contents and 0 returns the incoming WrData.

Ports:
- Clock, in, 1: the only clock. All logic updates on its rising edge.
- Reset, in, 1: synchronous, active-high.
- Flush, in, 1: synchronous clear of the pointer and occupancy. Memory contents are kept.
- WrValid, in, 1: write WrData at WrPtr this cycle.
- WrData, in, WD_DATA: decision vector to store.
- RdReq, in, 1: traceback read request.
- RdOffset, in, WD_ADDR: age of the requested word. 0 = newest stored word.
- RdValid, out, 1: RdData/RdErr are valid this cycle.
- RdData, out, WD_DATA: read result.
- RdErr, out, 1: requested offset was beyond the stored history.
- Count, out, WD_ADDR+1: number of valid words, 0..DEPTH.
- Full, out, 1: Count == DEPTH.

## Operation
- Write: when WrValid=1, mem[WrPtr] <= WrData and WrPtr <= WrPtr+1 (mod DEPTH, natural wrap). Count <= min(Count+1, DEPTH). Once Full, each write overwrites the oldest word. Writes are never refused.
- Read: on RdReq=1, RdAddr = (WrPtr − 1 − RdOffset) mod DEPTH, computed in WD_ADDR bits with wrap.
  - Hit: if RdOffset < Count, the read is a hit.
  - Miss: otherwise RdErr=1 and RdData=0.
- Evaluation point: all read decisions (RdAddr, the hit test) use the pre-edge WrPtr/Count, i.e. the state before any write or flush in the same cycle.
- Collision: occurs when Full=1, WrValid=1 and RdAddr == WrPtr (RdOffset = DEPTH−1).
  - READ_FIRST=1: returns the old (oldest) word.
  - READ_FIRST=0: returns the WrData of that cycle.
  - RdErr=0 in both cases.
- Flush: WrPtr <= 0, Count <= 0.
  - Flush with WrValid: the word goes to address 0; WrPtr <= 1, Count <= 1.
  - Precedence: Reset > Flush > write update.
- Reset values: WrPtr=0, Count=0, Full=0, RdValid=0, RdData=0, RdErr=0. The memory array is not reset.
- Reset mid-operation: a read issued in the same cycle as Reset is discarded. RdValid=0 on the next cycle.

## Timing
- Write latency: 1 cycle. A word written at edge N is readable at offset 0 by a RdReq sampled at edge N+1.
- Read latency: exactly 1 cycle. RdReq sampled at edge N gives RdValid/RdData/RdErr after edge N, for one cycle only.
- Back-to-back reads: one per cycle, fully pipelined, no stall.
- Output hold when idle: RdValid=0 when RdReq was 0. RdData and RdErr hold their last values.
- Count and Full are registered and update on the same edge as WrPtr.

## Structure
- Shared params.v defines:
  - `WD_RAM_ADDRESS (existing).
  - New `WD_SURV_DATA, the default decision width.
  - New `SURV_READ_FIRST, the default collision mode.
- Sub-module ram_sdp_core: simple dual-port array with one synchronous write port, one read port with registered output, and parameters WD_DATA/WD_ADDR. It contains no reset logic, so it maps to block RAM.
- survivor_ram holds:
  - WrPtr, Count and the hit/collision logic.
  - The collision bypass mux, using registered WrData plus a registered select.
  - The RdErr/RdValid pipeline register.

## Test plan
Defaults throughout (WD_DATA=8, WD_ADDR=2, DEPTH=4 in the bench).
- Reset, then write A5, 3C; read offsets 0, 1 → 3C, A5 with RdErr=0; Count=2, Full=0.
- Read offset 2 with Count=2 → RdValid=1, RdErr=1, RdData=00.
- Write 01..06 (6 writes, wrap) → Count=4, Full=1; offsets 0..3 → 06, 05, 04, 03.
- Collision check, with Full and history 03..06: read offset 3 while writing 77.
  - READ_FIRST=1 → RdData=03.
  - READ_FIRST=0 → RdData=77.
  - Next cycle, offset 0 → 77.
- Flush with WrValid (data 9E) → Count=1, WrPtr=1; offset 0 → 9E; offset 1 → RdErr=1.
- Assert Reset in the same cycle as RdReq (Count=3) → next cycle RdValid=0, Count=0, RdData=00, Full=0.
